// File: rtl/eeprom_req_arbiter_if.sv
// Bundle of requester-side and EEPROM-controller-side signals for eeprom_req_arbiter.
// slave = the arbiter's view; master = the hosts and EEPROM controller around it.
interface eeprom_req_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              wr0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              done0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              wr1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              done1;
    logic [DATA_W-1:0] rdata1;

    logic              ee_rd;
    logic              ee_wr;
    logic [ADDR_W-1:0] ee_addr;
    logic [DATA_W-1:0] ee_data_o;
    logic              ee_data_oe;
    logic [DATA_W-1:0] ee_data_i;
    logic              ee_ack;
    logic              busy;
    logic              err;

    modport slave (
        input  req0, wr0, addr0, wdata0, req1, wr1, addr1, wdata1, ee_data_i, ee_ack,
        output done0, rdata0, done1, rdata1, ee_rd, ee_wr, ee_addr, ee_data_o, ee_data_oe,
               busy, err
    );

    modport master (
        output req0, wr0, addr0, wdata0, req1, wr1, addr1, wdata1, ee_data_i, ee_ack,
        input  done0, rdata0, done1, rdata1, ee_rd, ee_wr, ee_addr, ee_data_o, ee_data_oe,
               busy, err
    );
endinterface

// File: rtl/eeprom_req_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of the EEPROM controller command port.
// Optional WAIT_ACK watchdog enabled by defining ARB_TIMEOUT_EN.
module eeprom_req_arbiter #(
    parameter int ADDR_W         = 11,
    parameter int DATA_W         = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    eeprom_req_arbiter_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, COMPLETE, GAP} state_t;

    localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    // Out-of-range configuration leaves an empty marker block in the elaborated hierarchy.
    if (GAP_CYCLES < 0 || GAP_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_param_out_of_range
    end

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              take;
    logic              pick;
    logic              op_wr;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic              ack_q;
    logic              ack_rise;
    logic              ack_pend;
    logic              ack_seen;
    logic [7:0]        gap_cnt;
    logic              timeout;
    logic              drive_bus;

    assign ack_rise = bus.ee_ack & ~ack_q;
    // An edge seen during ISSUE is carried into the first WAIT_ACK cycle.
    assign ack_seen = ack_rise | ack_pend;

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        pick      = last_grant;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    take      = 1'b1;
                    pick      = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:    state_nxt = WAIT_ACK;
            WAIT_ACK: if (ack_seen || timeout) state_nxt = COMPLETE;
            COMPLETE: state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:      if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            ack_q      <= 1'b0;
            ack_pend   <= 1'b0;
            gap_cnt    <= '0;
            op_wr      <= 1'b0;
            op_addr    <= '0;
            op_wdata   <= '0;
            bus.rdata0 <= '0;
            bus.rdata1 <= '0;
        end else begin
            state    <= state_nxt;
            ack_q    <= bus.ee_ack;
            ack_pend <= (state == ISSUE) && ack_rise;
            gap_cnt  <= (state == GAP) ? gap_cnt + 8'd1 : '0;
            if (take) begin
                last_grant <= pick;
                op_wr      <= pick ? bus.wr1    : bus.wr0;
                op_addr    <= pick ? bus.addr1  : bus.addr0;
                op_wdata   <= pick ? bus.wdata1 : bus.wdata0;
            end
            if (state == WAIT_ACK && ack_seen && !op_wr) begin
                if (last_grant) bus.rdata1 <= bus.ee_data_i;
                else            bus.rdata0 <= bus.ee_data_i;
            end
        end
    end

    // last_grant always names the requester that owns the operation in flight.
    assign drive_bus      = (state == ISSUE) || (state == WAIT_ACK);
    assign bus.ee_wr      = (state == ISSUE) &&  op_wr;
    assign bus.ee_rd      = (state == ISSUE) && !op_wr;
    assign bus.ee_addr    = drive_bus ? op_addr : '0;
    assign bus.ee_data_oe = drive_bus && op_wr;
    assign bus.ee_data_o  = bus.ee_data_oe ? op_wdata : '0;
    assign bus.done0      = (state == COMPLETE) && !last_grant;
    assign bus.done1      = (state == COMPLETE) &&  last_grant;
    assign bus.busy       = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_flag;

    assign timeout = (state == WAIT_ACK) && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            to_cnt <= (state == WAIT_ACK) ? to_cnt + 1'b1 : '0;
            // A real ack in the same cycle as expiry wins over the timeout.
            if (state == WAIT_ACK) to_flag <= timeout && !ack_seen;
        end
    end

    assign bus.err = (state == COMPLETE) && to_flag;
`else
    assign timeout = 1'b0;
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_eeprom_req_arbiter.sv
// Self-checking bench for eeprom_req_arbiter with a behavioural EEPROM controller model.
// Timeout scenario depends on ARB_TIMEOUT_EN.
module tb_eeprom_req_arbiter;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int GAP    = 4;
    localparam int TO     = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    eeprom_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    eeprom_req_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // EEPROM controller model: sees strobes 2ns after the edge, raises ack after ack_delay cycles
    logic [7:0]  mem [2048];
    int          ack_delay = 1;
    bit          ack_en    = 1'b1;
    int          cd        = -1;
    int          hold      = 0;
    int          cyc       = 0;
    int          last_ack  = -1;
    int          min_gap   = 1000;
    logic [10:0] m_addr    = '0;
    logic        m_wr      = 1'b0;

    initial begin
        bus.ee_ack    = 1'b0;
        bus.ee_data_i = '0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (reset) begin
                cd = -1; hold = 0; bus.ee_ack = 1'b0;
            end else begin
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) bus.ee_ack = 1'b0;
                end
                if (bus.ee_wr || bus.ee_rd) begin
                    if (last_ack >= 0 && (cyc - last_ack - 1) < min_gap) min_gap = cyc - last_ack - 1;
                    m_addr = bus.ee_addr;
                    m_wr   = bus.ee_wr;
                    if (bus.ee_wr) mem[bus.ee_addr] = bus.ee_data_o;
                    if (ack_en) cd = ack_delay;
                end
                if (cd == 0) begin
                    bus.ee_ack = 1'b1;
                    hold       = 2;
                    last_ack   = cyc;
                    if (!m_wr) bus.ee_data_i = mem[m_addr];
                    cd = -1;
                end else if (cd > 0) begin
                    cd--;
                end
            end
        end
    end

    task automatic do_op(input int r, input logic w, input logic [10:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output bit to);
        if (r == 0) begin bus.wr0 = w; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1; end
        else        begin bus.wr1 = w; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1; end
        to = 1'b1;
        rd = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (r == 0 && bus.done0) begin rd = bus.rdata0; to = 1'b0; break; end
            if (r == 1 && bus.done1) begin rd = bus.rdata1; to = 1'b0; break; end
        end
        if (r == 0) bus.req0 = 1'b0;
        else        bus.req1 = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0]  strobes;
        logic [18:0] addr_data;
        logic [15:0] rdatas;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        strobes   = {bus.ee_rd, bus.ee_wr, bus.ee_data_oe, bus.err};
        addr_data = {bus.ee_addr, bus.ee_data_o};
        rdatas    = {bus.rdata0, bus.rdata1};
        checks++;
        if (strobes !== 4'h0) begin failures++; $display("FAIL reset_strobes: got %0h expected 0", strobes); end
        checks++;
        if (addr_data !== '0) begin failures++; $display("FAIL reset_addr_data: got %0h expected 0", addr_data); end
        checks++;
        if ({bus.done0, bus.done1} !== 2'b00) begin
            failures++; $display("FAIL reset_done: got %0b expected 00", {bus.done0, bus.done1});
        end
        checks++;
        if (rdatas !== '0) begin failures++; $display("FAIL reset_rdata: got %0h expected 0", rdatas); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        int wr_hi = 0, rd_hi = 0, hold_bad = 0, ack_i = -1, done_i = -1, done_cnt = 0;
        bit seen = 1'b0;
        ack_en = 1'b1; ack_delay = 10;
        bus.wr0 = 1'b1; bus.addr0 = 11'h2A5; bus.wdata0 = 8'h5C; bus.req0 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.ee_wr) begin wr_hi++; seen = 1'b1; end
            if (bus.ee_rd) rd_hi++;
            if (seen && ack_i < 0) begin
                if (bus.ee_addr !== 11'h2A5 || bus.ee_data_o !== 8'h5C || bus.ee_data_oe !== 1'b1) hold_bad++;
                if (bus.ee_ack) ack_i = i;
            end
            if (bus.done0) begin done_cnt++; if (done_i < 0) done_i = i; bus.req0 = 1'b0; end
        end
        checks++;
        if (wr_hi != 1) begin failures++; $display("FAIL write_strobe_width: got %0d expected 1", wr_hi); end
        checks++;
        if (rd_hi != 0) begin failures++; $display("FAIL write_no_rd: got %0d expected 0", rd_hi); end
        checks++;
        if (hold_bad != 0) begin failures++; $display("FAIL write_hold: got %0d bad cycles expected 0", hold_bad); end
        checks++;
        if (ack_i < 0 || done_i != ack_i + 1) begin
            failures++; $display("FAIL write_done_latency: got done at %0d expected %0d", done_i, ack_i + 1);
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL write_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_single_read();
        int rd_hi = 0, wr_hi = 0, oe_hi = 0, d1 = 0, d0 = 0;
        logic [7:0] got = '0;
        mem[11'h7FF] = 8'hA3;
        ack_en = 1'b1; ack_delay = 3;
        bus.wr1 = 1'b0; bus.addr1 = 11'h7FF; bus.wdata1 = 8'hFF; bus.req1 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ee_rd) rd_hi++;
            if (bus.ee_wr) wr_hi++;
            if (bus.ee_data_oe) oe_hi++;
            if (bus.done0) d0++;
            if (bus.done1) begin d1++; got = bus.rdata1; bus.req1 = 1'b0; end
        end
        checks++;
        if (rd_hi != 1 || wr_hi != 0) begin
            failures++; $display("FAIL read_strobes: got rd=%0d wr=%0d expected rd=1 wr=0", rd_hi, wr_hi);
        end
        checks++;
        if (oe_hi != 0) begin failures++; $display("FAIL read_oe: got %0d cycles expected 0", oe_hi); end
        checks++;
        if (d1 != 1 || d0 != 0) begin
            failures++; $display("FAIL read_done: got done1=%0d done0=%0d expected 1 0", d1, d0);
        end
        checks++;
        if (got !== 8'hA3) begin failures++; $display("FAIL read_data: got %0h expected a3", got); end
        checks++;
        if (bus.rdata1 !== 8'hA3) begin failures++; $display("FAIL read_data_hold: got %0h expected a3", bus.rdata1); end
    endtask

    task automatic test_contention();
        int exp_q[$];
        int n = 0, g, e;
        reset = 1'b1;
        bus.wr0 = 1'b1; bus.addr0 = 11'h010; bus.wdata0 = 8'h11; bus.req0 = 1'b1;
        bus.wr1 = 1'b0; bus.addr1 = 11'h010; bus.req1 = 1'b1;
        ack_en = 1'b1; ack_delay = 2;
        repeat (2) @(negedge clk);
        last_ack = -1; min_gap = 1000;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
        reset = 1'b0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            @(negedge clk);
            if (bus.done0 || bus.done1) begin
                g = bus.done1 ? 1 : 0;
                e = exp_q.pop_front();
                checks++;
                if (g != e || (bus.done0 && bus.done1)) begin
                    failures++; $display("FAIL grant_order[%0d]: got %0d expected %0d", n, g, e);
                end
                n++;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        checks++;
        if (n != 4) begin failures++; $display("FAIL contention_ops: got %0d expected 4", n); end
        checks++;
        if (min_gap < GAP) begin failures++; $display("FAIL gap_cycles: got %0d expected >= %0d", min_gap, GAP); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [18:0] sb[$];
        logic [18:0] ent;
        logic [10:0] base, a;
        logic [7:0]  d, rd;
        bit          to;
        base = 11'($urandom_range(0, 2047));
        for (int i = 0; i < 50; i++) begin
            a = base + 11'(i * 41);
            d = 8'($urandom);
            ack_delay = $urandom_range(0, 5);
            do_op(0, 1'b1, a, d, rd, to);
            checks++;
            if (to) begin failures++; $display("FAIL wr_op_timeout[%0d]: got no done0 expected done0", i); end
            sb.push_back({a, d});
        end
        for (int i = 0; i < 50; i++) begin
            ent = sb.pop_front();
            ack_delay = $urandom_range(0, 5);
            do_op(1, 1'b0, ent[18:8], 8'h00, rd, to);
            checks++;
            if (to || rd !== ent[7:0]) begin
                failures++;
                $display("FAIL readback[%0d] addr %0h: got %0h expected %0h", i, ent[18:8], rd, ent[7:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd;
        bit to, seen = 1'b0;
        int d0 = 0;
        ack_en = 1'b0;
        bus.wr0 = 1'b1; bus.addr0 = 11'h005; bus.wdata0 = 8'h77; bus.req0 = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.ee_wr) seen = 1'b1;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (!seen || bus.busy !== 1'b1 || bus.ee_data_oe !== 1'b1) begin
            failures++; $display("FAIL mid_wait_ack: got busy=%0b oe=%0b expected 1 1", bus.busy, bus.ee_data_oe);
        end
        reset = 1'b1; bus.req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.ee_rd, bus.ee_wr, bus.ee_data_oe, bus.ee_addr, bus.ee_data_o, bus.busy, bus.done0} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got oe=%0b addr=%0h busy=%0b expected 0", bus.ee_data_oe, bus.ee_addr, bus.busy);
        end
        checks++;
        if ({bus.rdata0, bus.rdata1} !== '0) begin
            failures++; $display("FAIL mid_reset_rdata: got %0h expected 0", {bus.rdata0, bus.rdata1});
        end
        reset = 1'b0; ack_en = 1'b1; ack_delay = 4;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done0 || bus.done1) d0++;
        end
        checks++;
        if (d0 != 0) begin failures++; $display("FAIL mid_no_done: got %0d expected 0", d0); end
        do_op(0, 1'b1, 11'h123, 8'h9E, rd, to);
        do_op(0, 1'b0, 11'h123, 8'h00, rd, to);
        checks++;
        if (to || rd !== 8'h9E) begin failures++; $display("FAIL after_reset_op: got %0h expected 9e", rd); end
    endtask

    task automatic test_timeout();
        int s = -1, e = -1, d = -1, b = -1, ec = 0;
        logic [7:0] prev;
        prev = bus.rdata0;
        ack_en = 1'b0;
        bus.wr0 = 1'b0; bus.addr0 = 11'h055; bus.req0 = 1'b1;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.ee_rd && s < 0) s = i;
            if (bus.err) begin ec++; if (e < 0) e = i; end
            if (bus.done0 && d < 0) begin d = i; bus.req0 = 1'b0; end
            if (e >= 0 && b < 0 && !bus.busy) b = i;
        end
        checks++;
        if (s < 0 || e - s != TO + 1) begin failures++; $display("FAIL timeout_err_time: got %0d expected %0d", e - s, TO + 1); end
        checks++;
        if (d != e || ec != 1) begin failures++; $display("FAIL timeout_done: got done@%0d errs=%0d expected done@%0d errs=1", d, ec, e); end
        checks++;
        if (bus.rdata0 !== prev) begin failures++; $display("FAIL timeout_rdata: got %0h expected %0h", bus.rdata0, prev); end
        checks++;
        if (b != e + GAP + 1) begin failures++; $display("FAIL timeout_busy_drop: got %0d expected %0d", b, e + GAP + 1); end
`else
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.err) ec++;
            if (bus.done0) d = i;
        end
        checks++;
        if (ec != 0 || d >= 0) begin failures++; $display("FAIL no_timeout: got err=%0d done@%0d expected none", ec, d); end
        checks++;
        if (bus.busy !== 1'b1 || bus.rdata0 !== prev) begin
            failures++; $display("FAIL wait_forever: got busy=%0b rdata0=%0h expected 1 %0h", bus.busy, bus.rdata0, prev);
        end
        reset = 1'b1; bus.req0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
`endif
        ack_en = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        bus.req0 = 1'b0; bus.wr0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.wr1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
